// File: rtl/strrec_pkg.sv
// Shared definitions for the string-recognition datapath: shift-register
// mode codes, matcher FSM states and the default register width.
package strrec_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ROR  = 2'b01;
    localparam logic [1:0] MODE_ROL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

endpackage

// File: rtl/rot_pattern_matcher.sv
// Watches a rotating universal shift register and reports how many rotation
// steps it took for the register to reach a latched target pattern, or a miss
// once every position has been examined.
module rot_pattern_matcher
    import strrec_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p,
    input  logic [1:0]       s,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    output logic             busy,
    output logic             found,
    output logic             miss,
    output logic [CW-1:0]    steps
);

    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ALL_POS  = CW'(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tgt;
    logic             dir_valid;
    logic [1:0]       dir;

    // Search FSM with inline rotation counter; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            found     <= 1'b0;
            miss      <= 1'b0;
            steps     <= '0;
            cnt       <= '0;
            tgt       <= '0;
            dir_valid <= 1'b0;
            dir       <= MODE_HOLD;
        end else begin
            // Pulses are low on every edge except the one that raises them.
            found <= 1'b0;
            miss  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt       <= target;
                        cnt       <= '0;
                        dir_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (p == tgt) begin
                        found <= 1'b1;
                        steps <= cnt;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == LAST_POS) begin
                        miss  <= 1'b1;
                        steps <= ALL_POS;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (s == MODE_LOAD) begin
                        // A fresh value enters the register; count from scratch.
                        cnt       <= '0;
                        dir_valid <= 1'b0;
                    end else if (s == MODE_ROR || s == MODE_ROL) begin
                        if (!dir_valid || s == dir) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            // Reversal: the current position becomes the new origin.
                            cnt <= '0;
                        end
                        dir       <= s;
                        dir_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rot_pattern_matcher.sv
// Directed bench for rot_pattern_matcher: register contents and mode codes are
// driven cycle by cycle, outputs checked one time unit after each rising edge.
module tb_rot_pattern_matcher;

    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] p;
    logic [1:0]       s;
    logic             start;
    logic [WIDTH-1:0] target;
    logic             busy;
    logic             found;
    logic             miss;
    logic [CW-1:0]    steps;

    int compared   = 0;
    int mismatched = 0;

    rot_pattern_matcher #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .p      (p),
        .s      (s),
        .start  (start),
        .target (target),
        .busy   (busy),
        .found  (found),
        .miss   (miss),
        .steps  (steps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample after the edge.
    task automatic step(input logic [3:0] pv, input logic [1:0] sv,
                        input logic st, input logic [3:0] tg, input logic r);
        @(negedge clk);
        p = pv; s = sv; start = st; target = tg; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic b, input logic f,
                           input logic m, input logic [CW-1:0] st);
        chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
        chk({tag, ".found"}, {31'd0, found}, {31'd0, f});
        chk({tag, ".miss"},  {31'd0, miss},  {31'd0, m});
        chk({tag, ".steps"}, {29'd0, steps}, {29'd0, st});
    endtask

    initial begin
        p = 4'b0000; s = 2'b00; start = 1'b0; target = 4'b0000; rst = 1'b1;

        // Reset state
        step(4'b0000, 2'b00, 1'b0, 4'b0000, 1'b1);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 3'd0);
        step(4'b0000, 2'b00, 1'b0, 4'b0000, 1'b0);
        chk_out("idle", 1'b0, 1'b0, 1'b0, 3'd0);

        // Rotate-left match: 0110 -> 1100, steps=1
        step(4'b0110, 2'b00, 1'b1, 4'b1100, 1'b0);
        chk_out("rol.start", 1'b1, 1'b0, 1'b0, 3'd0);
        step(4'b0110, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("rol.c1", 1'b1, 1'b0, 1'b0, 3'd0);
        step(4'b1100, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("rol.found", 1'b0, 1'b1, 1'b0, 3'd1);
        step(4'b1001, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("rol.after", 1'b0, 1'b0, 1'b0, 3'd1);

        // Rotate-right match: 0110 -> 0011 -> 1001, steps=2
        step(4'b0110, 2'b00, 1'b1, 4'b1001, 1'b0);
        chk_out("ror.start", 1'b1, 1'b0, 1'b0, 3'd1);
        step(4'b0110, 2'b01, 1'b0, 4'b0000, 1'b0);
        step(4'b0011, 2'b01, 1'b0, 4'b0000, 1'b0);
        chk_out("ror.c2", 1'b1, 1'b0, 1'b0, 3'd1);
        step(4'b1001, 2'b01, 1'b0, 4'b0000, 1'b0);
        chk_out("ror.found", 1'b0, 1'b1, 1'b0, 3'd2);

        // Miss: target 1111 never appears under rotate-left
        step(4'b0110, 2'b00, 1'b1, 4'b1111, 1'b0);
        step(4'b0110, 2'b10, 1'b0, 4'b0000, 1'b0);
        step(4'b1100, 2'b10, 1'b0, 4'b0000, 1'b0);
        step(4'b1001, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("miss.c3", 1'b1, 1'b0, 1'b0, 3'd2);
        step(4'b0011, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("miss.pulse", 1'b0, 1'b0, 1'b1, 3'd4);
        step(4'b0110, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("miss.after", 1'b0, 1'b0, 1'b0, 3'd4);

        // Hold then load: holds keep cnt at 0, load restarts counting
        step(4'b0110, 2'b00, 1'b1, 4'b0011, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0110, 2'b00, 1'b0, 4'b0000, 1'b0);
            chk_out("hold", 1'b1, 1'b0, 1'b0, 3'd4);
        end
        step(4'b0110, 2'b11, 1'b0, 4'b0000, 1'b0);
        step(4'b1000, 2'b01, 1'b0, 4'b0000, 1'b0);
        step(4'b0100, 2'b01, 1'b0, 4'b0000, 1'b0);
        chk_out("load.c2", 1'b1, 1'b0, 1'b0, 3'd4);
        step(4'b0010, 2'b01, 1'b0, 4'b0000, 1'b0);
        chk_out("load.c3", 1'b1, 1'b0, 1'b0, 3'd4);
        step(4'b0001, 2'b01, 1'b0, 4'b0000, 1'b0);
        chk_out("load.miss", 1'b0, 1'b0, 1'b1, 3'd4);

        // Direction reversal restarts the count from the current position
        step(4'b0110, 2'b00, 1'b1, 4'b1111, 1'b0);
        step(4'b0110, 2'b01, 1'b0, 4'b0000, 1'b0);
        step(4'b0011, 2'b10, 1'b0, 4'b0000, 1'b0);
        step(4'b0110, 2'b10, 1'b0, 4'b0000, 1'b0);
        step(4'b1100, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("rev.c2", 1'b1, 1'b0, 1'b0, 3'd4);
        step(4'b1001, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("rev.c3", 1'b1, 1'b0, 1'b0, 3'd4);
        step(4'b0011, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("rev.miss", 1'b0, 1'b0, 1'b1, 3'd4);

        // Immediate match, start ignored in SEARCH, start accepted in found cycle
        step(4'b0101, 2'b00, 1'b1, 4'b0101, 1'b0);
        chk_out("imm.start", 1'b1, 1'b0, 1'b0, 3'd4);
        step(4'b0101, 2'b00, 1'b1, 4'b1111, 1'b0);
        chk_out("imm.found", 1'b0, 1'b1, 1'b0, 3'd0);
        step(4'b0101, 2'b00, 1'b1, 4'b1010, 1'b0);
        chk_out("imm.restart", 1'b1, 1'b0, 1'b0, 3'd0);
        step(4'b0101, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("imm.c1", 1'b1, 1'b0, 1'b0, 3'd0);
        step(4'b1010, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("imm.found2", 1'b0, 1'b1, 1'b0, 3'd1);

        // Reset mid-search aborts without a pulse
        step(4'b0110, 2'b00, 1'b1, 4'b1111, 1'b0);
        step(4'b0110, 2'b10, 1'b0, 4'b0000, 1'b0);
        step(4'b1100, 2'b10, 1'b0, 4'b0000, 1'b0);
        step(4'b1001, 2'b10, 1'b0, 4'b0000, 1'b1);
        chk_out("rst.mid", 1'b0, 1'b0, 1'b0, 3'd0);
        step(4'b0011, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("rst.idle", 1'b0, 1'b0, 1'b0, 3'd0);
        step(4'b0110, 2'b00, 1'b1, 4'b1100, 1'b0);
        chk_out("rst.start", 1'b1, 1'b0, 1'b0, 3'd0);
        step(4'b0110, 2'b10, 1'b0, 4'b0000, 1'b0);
        step(4'b1100, 2'b10, 1'b0, 4'b0000, 1'b0);
        chk_out("rst.found", 1'b0, 1'b1, 1'b0, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
